// File: rtl/uart_rx_ctrl_pkg.sv
// Shared types and defaults for the UART receive controller slice.
package uart_pkg;

    localparam int UART_PAYLOAD_BITS = 8;
    localparam int UART_FRAME_CYCLES = 80;

    typedef enum logic [1:0] {
        OFF   = 2'd0,
        ARM   = 2'd1,
        RUN   = 2'd2,
        DRAIN = 2'd3
    } rx_ctrl_state_t;

endpackage

// File: rtl/uart_rx_ctrl_if.sv
// Receiver-side and software-read-side signals of the UART receive controller.
interface uart_rx_ctrl_if
    import uart_pkg::*;
#(
    parameter int PAYLOAD_BITS = UART_PAYLOAD_BITS,
    parameter int FIFO_DEPTH   = 8
);
    localparam int LW = $clog2(FIFO_DEPTH) + 1;

    logic                    rx_en;
    logic                    rx_valid;
    logic                    rx_break;
    logic [PAYLOAD_BITS-1:0] rx_data;
    logic                    rd_req;
    logic [PAYLOAD_BITS-1:0] rd_data;
    logic                    rd_valid;
    logic [LW-1:0]           level;

    modport slave  (output rx_en, rd_data, rd_valid, level,
                    input  rx_valid, rx_break, rx_data, rd_req);
    modport master (input  rx_en, rd_data, rd_valid, level,
                    output rx_valid, rx_break, rx_data, rd_req);

endinterface

// File: rtl/uart_rx_fifo.sv
// Show-ahead receive FIFO; a push while full is accepted only if a pop frees a slot that cycle.
module uart_rx_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 8,
    parameter int LW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [W-1:0]  wr_data,
    input  logic          pop,
    output logic [W-1:0]  rd_data,
    output logic          full,
    output logic          empty,
    output logic [LW-1:0] level
);
    localparam int AW = $clog2(DEPTH);

    logic [DEPTH-1:0][W-1:0] mem;
    logic [AW-1:0]           wr_ptr, rd_ptr;
    logic                    do_push, do_pop;

    assign empty   = (level == '0);
    assign full    = (level == LW'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rd_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wr_data;
    end

    // Depth is a power of two, so pointer wrap is the natural overflow.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: enable sequencing FSM, receive FIFO, sticky flags and irq.
// Optional idle-timeout flag built when UART_RX_TIMEOUT_EN is defined.
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int PAYLOAD_BITS   = UART_PAYLOAD_BITS,
    parameter int FIFO_DEPTH     = 8,
    parameter int WATERMARK      = 4,
    parameter int FRAME_CYCLES   = UART_FRAME_CYCLES,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           ctrl_en,
    input  logic           clr_err,
    uart_rx_ctrl_if.slave  bus,
    output logic           overrun,
    output logic           break_det,
    output logic           timeout,
    output logic           irq
);
    localparam int LW = $clog2(FIFO_DEPTH) + 1;
    localparam int CW = $clog2(FRAME_CYCLES) + 1;

    localparam logic [1:0] ST_OFF   = OFF;
    localparam logic [1:0] ST_ARM   = ARM;
    localparam logic [1:0] ST_RUN   = RUN;
    localparam logic [1:0] ST_DRAIN = DRAIN;

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("FIFO_DEPTH must be a power of two >= 2");
    end
    if (WATERMARK < 1 || WATERMARK > FIFO_DEPTH || FRAME_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
        $error("WATERMARK, FRAME_CYCLES or TIMEOUT_CYCLES out of range");
    end

    logic [1:0]    state, state_nxt;
    logic [CW-1:0] seq_cnt;
    logic          active, push_req, pop_req, brk_set, ovr_set;
    logic          fifo_full, fifo_empty;

    assign active   = (state == ST_RUN) || (state == ST_DRAIN);
    assign push_req = active && bus.rx_valid && !bus.rx_break;
    assign brk_set  = active && bus.rx_valid && bus.rx_break;
    assign pop_req  = bus.rd_req;
    assign ovr_set  = push_req && fifo_full && !pop_req;
    assign bus.rx_en    = (state != ST_OFF);
    assign bus.rd_valid = !fifo_empty;

    always_comb begin
        state_nxt = state;
        case (state)
            ST_OFF:   if (ctrl_en) state_nxt = ST_ARM;
            ST_ARM:   if (!ctrl_en) state_nxt = ST_OFF;
                      else if (seq_cnt == CW'(1)) state_nxt = ST_RUN;
            ST_RUN:   if (!ctrl_en) state_nxt = ST_DRAIN;
            ST_DRAIN: if (ctrl_en) state_nxt = ST_RUN;
                      else if (bus.rx_valid || seq_cnt == CW'(FRAME_CYCLES - 1)) state_nxt = ST_OFF;
            default:  state_nxt = ST_OFF;
        endcase
    end

    // seq_cnt times the synchronizer flush in ARM and the drain window in DRAIN.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= ST_OFF;
            seq_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (state_nxt != state || !(state == ST_ARM || state == ST_DRAIN)) seq_cnt <= '0;
            else seq_cnt <= seq_cnt + 1'b1;
        end
    end

    uart_rx_fifo #(.W(PAYLOAD_BITS), .DEPTH(FIFO_DEPTH), .LW(LW)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (push_req),
        .wr_data (bus.rx_data),
        .pop     (pop_req),
        .rd_data (bus.rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (bus.level)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            overrun   <= 1'b0;
            break_det <= 1'b0;
            irq       <= 1'b0;
        end else begin
            if (ovr_set) overrun <= 1'b1;
            else if (clr_err) overrun <= 1'b0;
            if (brk_set) break_det <= 1'b1;
            else if (clr_err) break_det <= 1'b0;
            irq <= overrun || break_det || timeout || (bus.level >= LW'(WATERMARK));
        end
    end

`ifdef UART_RX_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;

    logic [TW-1:0] to_cnt;
    logic          do_push, do_pop, to_clr, to_inc, to_hit, to_flag;

    assign do_pop  = pop_req && !fifo_empty;
    assign do_push = push_req && (!fifo_full || pop_req);
    assign to_clr  = do_push || do_pop || (state_nxt != state);
    assign to_inc  = !to_clr && (state == ST_RUN) && !fifo_empty && (to_cnt != TW'(TIMEOUT_CYCLES));
    assign to_hit  = to_inc && (to_cnt == TW'(TIMEOUT_CYCLES - 1));
    assign timeout = to_flag;

    // Counter saturates at the threshold so a stale FIFO raises the flag once.
    always_ff @(posedge clk) begin
        if (!rst_n || to_clr) to_cnt <= '0;
        else if (to_inc) to_cnt <= to_cnt + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) to_flag <= 1'b0;
        else if (to_hit) to_flag <= 1'b1;
        else if (do_pop || clr_err) to_flag <= 1'b0;
    end
`else
    assign timeout = 1'b0;
`endif

endmodule
